mux16_rr_arbiter: RTL and testbench
===================================

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, Ack-wait limit in cycles per grant; legal range 1..255.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 Req  input  16  request lines, Req[i] from requester i.
REQ-005 W  input  16  data bits, W[i] driven by requester i.
REQ-006 Ack  input  1  consumer accepts current bit; sampled on rising edge.
REQ-007 Sel  output  4  registered select code of current owner, for the shared 16:1 mux.
REQ-008 Grant  output  16  registered one-hot grant, Grant[Sel] only.
REQ-009 Valid  output  1  registered; high while a grant is active.
REQ-010 F  output  1  combinational: W[Sel] when Valid=1, else 0.
REQ-011 Err  output  1  registered one-cycle pulse on timeout.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, RECOVER.
REQ-013 Ptr (4-bit) SHALL hold the highest-priority index; search order is Ptr, Ptr+1, ..., Ptr+15, all mod 16.
REQ-014 In IDLE with Req nonzero, the block SHALL load Sel with the first asserted index in search order, set Grant=1<<Sel and Valid=1, clear the wait counter, and enter GRANT on the next edge (1-cycle request-to-grant latency).
REQ-015 In IDLE with Req=0, outputs SHALL hold Valid=0, Grant=0, and Sel at its last value.
REQ-016 In GRANT, Sel and Grant SHALL stay stable until the state is exited.
REQ-017 In GRANT with Ack=1, the block SHALL set Ptr=Sel+1 (wrap 15->0), drop Valid/Grant, and enter RECOVER.
REQ-018 In GRANT with Ack=0 and Req[Sel]=0, the block SHALL release exactly as in REQ-017: Ptr advances, no Err.
REQ-019 In GRANT with Ack=0 and Req[Sel]=1, the wait counter SHALL increment; when it reaches TIMEOUT, the block SHALL pulse Err for one cycle, advance Ptr=Sel+1, drop Valid/Grant, and enter RECOVER.
REQ-020 If Ack=1 and the timeout fire in the same cycle, Ack SHALL win: no Err.
REQ-021 RECOVER SHALL last exactly one cycle with Valid=0 and then return to IDLE; the minimum grant-to-grant spacing is 3 cycles.
REQ-022 Changes on Req during GRANT SHALL NOT alter Sel; they are evaluated only in IDLE.
REQ-023 Requests from any index other than the current owner SHALL NOT cause Err.
REQ-024 Fairness: with all 16 requests held high and Ack returned on the first GRANT cycle, grants SHALL visit indices in strict cyclic order.
REQ-025 Ack sampled in IDLE or RECOVER SHALL be ignored.

Reset
REQ-026 While Resetn=0: state=IDLE, Ptr=0, Sel=0, Grant=0, Valid=0, Err=0, wait counter=0; F=0.
REQ-027 Reset asserted in GRANT or RECOVER SHALL abort immediately (asynchronously) without Err; after release, arbitration restarts from Ptr=0.

Verification
REQ-028 After reset, Req=16'h0001, W[0]=1, Ack high for 1 cycle once Valid=1 -> Sel=0, Grant=16'h0001, F=1 one cycle after the request; Ptr=1 afterwards; Valid low for 2 cycles.
REQ-029 Req=16'hFFFF held, Ack tied high -> Sel sequence 0,1,2,...,15,0 with a grant every 3 cycles; no Err.
REQ-030 Ptr=14 (after granting 13), Req=16'h2001 -> grant goes to index 0 (wrap), not 13; then to 13 on the next arbitration.
REQ-031 TIMEOUT=15, Req=16'h0010, Ack=0 -> Valid high for 15 cycles, single Err pulse, Ptr=5, re-grant of 4 after RECOVER.
REQ-032 Grant to index 7, then Req[7] drops with Ack=0 -> release on the next edge, no Err, Ptr=8; Ack and timeout coincident on cycle TIMEOUT -> no Err.
REQ-033 Resetn pulsed low mid-GRANT -> all outputs 0 immediately, no Err; the next grant is searched from Ptr=0.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for 16 single-bit requesters sharing one 16:1 data mux.
// The owner holds the grant until Ack, until it drops its request, or until the ack-wait limit expires.
module mux16_rr_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] Req,
    input  logic [15:0] W,
    input  logic        Ack,
    output logic [3:0]  Sel,
    output logic [15:0] Grant,
    output logic        Valid,
    output logic        F,
    output logic        Err,
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_ptr
);

    // Handshake: a transfer happens on a rising edge where Valid=1 and Ack=1.
    // Ack outside GRANT has no effect; F is only meaningful while Valid=1.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [3:0]  ptr, ptr_nxt;
    logic [3:0]  sel_nxt;
    logic [15:0] grant_nxt;
    logic        valid_nxt;
    logic        err_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic [7:0]  wait_inc;

    logic [31:0] req_rot_wide;
    logic [15:0] req_rot;
    logic [3:0]  offset;
    logic [3:0]  pick;
    logic        found;

    // Rotate so bit 0 is the highest-priority requester, then take the lowest set bit.
    assign req_rot_wide = {Req, Req} >> ptr;
    assign req_rot      = req_rot_wide[15:0];
    assign found        = |Req;

    always_comb begin
        offset = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = 4'(i);
            end
        end
    end

    assign pick     = 4'(ptr + offset);
    assign wait_inc = 8'(wait_cnt + 8'd1);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            ptr      <= 4'd0;
            Sel      <= 4'd0;
            Grant    <= 16'd0;
            Valid    <= 1'b0;
            Err      <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            Sel      <= sel_nxt;
            Grant    <= grant_nxt;
            Valid    <= valid_nxt;
            Err      <= err_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = Sel;
        grant_nxt = Grant;
        valid_nxt = Valid;
        err_nxt   = 1'b0;
        wait_nxt  = wait_cnt;

        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                grant_nxt = 16'd0;
                wait_nxt  = 8'd0;
                if (found) begin
                    sel_nxt   = pick;
                    grant_nxt = 16'd1 << pick;
                    valid_nxt = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Ack takes precedence over a timeout landing on the same edge.
                if (Ack || !Req[Sel] || (wait_inc == TIMEOUT_W)) begin
                    ptr_nxt   = 4'(Sel + 4'd1);
                    valid_nxt = 1'b0;
                    grant_nxt = 16'd0;
                    wait_nxt  = 8'd0;
                    err_nxt   = !Ack && Req[Sel];
                    state_nxt = RECOVER;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            RECOVER: begin
                valid_nxt = 1'b0;
                grant_nxt = 16'd0;
                state_nxt = IDLE;
            end
            default: begin
                valid_nxt = 1'b0;
                grant_nxt = 16'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign F         = Valid ? W[Sel] : 1'b0;
    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: expected grants are queued by the stimulus
// and checked by a monitor whenever a new grant appears.
module tb_mux16_rr_arbiter;

    logic        Clock;
    logic        Resetn;
    logic [15:0] Req;
    logic [15:0] w;
    logic        Ack;
    logic [3:0]  Sel;
    logic [15:0] Grant;
    logic        Valid;
    logic        F;
    logic        Err;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_ptr;

    int tests = 0;
    int fails = 0;
    int err_seen = 0;
    logic prev_valid = 1'b0;
    logic [4:0] exp_q[$];

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    mux16_rr_arbiter #(.TIMEOUT(15)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Req       (Req),
        .W         (w),
        .Ack       (Ack),
        .Sel       (Sel),
        .Grant     (Grant),
        .Valid     (Valid),
        .F         (F),
        .Err       (Err),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Req    = 16'd0;
        Ack    = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
    endtask

    task automatic push_exp(input logic [3:0] s);
        exp_q.push_back({s, w[s]});
    endtask

    // One complete grant with Ack on the first GRANT cycle.
    task automatic do_grant(input logic [15:0] req, input logic [15:0] req_after,
                            input logic [3:0] exp_sel);
        Req = req;
        push_exp(exp_sel);
        tick();
        check("grant_valid", {31'd0, Valid}, 32'd1);
        check("grant_state", {30'd0, dbg_state}, {30'd0, S_GRANT});
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        Req = req_after;
        check("recover_valid", {31'd0, Valid}, 32'd0);
        check("recover_err", {31'd0, Err}, 32'd0);
        tick();
        check("idle_valid", {31'd0, Valid}, 32'd0);
        check("ptr_after", {28'd0, dbg_ptr}, {28'd0, 4'(exp_sel + 4'd1)});
    endtask

    // scoreboard monitor
    always @(negedge Clock) begin
        logic [4:0] e;
        if (!Resetn) begin
            prev_valid = 1'b0;
        end else begin
            if (Err) err_seen++;
            if (Valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_grant: got sel %0d expected no grant at %0t", Sel, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_sel", {28'd0, Sel}, {28'd0, e[4:1]});
                    check("mon_grant", {16'd0, Grant}, {16'd0, 16'd1 << e[4:1]});
                    check("mon_f", {31'd0, F}, {31'd0, e[0]});
                end
            end
            prev_valid = Valid;
        end
    end

    initial begin
        #500000;
        tests++;
        fails++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int vcnt;
        Resetn = 1'b0;
        Req    = 16'd0;
        Ack    = 1'b0;
        w      = 16'd0;
        #3;
        check("rst_sel", {28'd0, Sel}, 32'd0);
        check("rst_grant", {16'd0, Grant}, 32'd0);
        check("rst_valid", {31'd0, Valid}, 32'd0);
        check("rst_err", {31'd0, Err}, 32'd0);
        check("rst_f", {31'd0, F}, 32'd0);
        check("rst_ptr", {28'd0, dbg_ptr}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        tick();
        tick();
        Resetn = 1'b1;

        // single requester 0, F follows W[0]
        w = 16'h0001;
        do_grant(16'h0001, 16'h0000, 4'd0);
        check("err_single", err_seen, 32'd0);

        // all requesting, Ack held: strict cyclic order, grant every 3 cycles
        do_reset();
        w   = 16'hA5C3;
        for (int k = 0; k < 17; k++) push_exp(4'(k));
        Req = 16'hFFFF;
        Ack = 1'b1;
        tick();
        for (int k = 0; k < 17; k++) begin
            check("fair_valid", {31'd0, Valid}, 32'd1);
            tick();
            if (k == 16) Req = 16'h0000;
            check("fair_gap1", {31'd0, Valid}, 32'd0);
            tick();
            check("fair_gap2", {31'd0, Valid}, 32'd0);
            tick();
        end
        Ack = 1'b0;
        check("fair_no_grant", {31'd0, Valid}, 32'd0);
        check("fair_ptr", {28'd0, dbg_ptr}, 32'd1);
        check("err_fair", err_seen, 32'd0);

        // wrap-around priority from Ptr=14
        do_reset();
        w = 16'h2000;
        do_grant(16'h2000, 16'h2001, 4'd13);
        do_grant(16'h2001, 16'h2001, 4'd0);
        do_grant(16'h2001, 16'h0000, 4'd13);
        tick();
        check("err_wrap", err_seen, 32'd0);

        // timeout on requester 4, then re-grant
        do_reset();
        w   = 16'h0010;
        Req = 16'h0010;
        push_exp(4'd4);
        tick();
        vcnt = 0;
        while (Valid && vcnt < 40) begin
            vcnt++;
            tick();
        end
        check("to_valid_cycles", vcnt, 32'd15);
        check("to_err_pulse", {31'd0, Err}, 32'd1);
        check("to_ptr", {28'd0, dbg_ptr}, 32'd5);
        check("to_state", {30'd0, dbg_state}, {30'd0, S_RECOVER});
        push_exp(4'd4);
        tick();
        check("to_err_single", {31'd0, Err}, 32'd0);
        tick();
        check("to_regrant", {31'd0, Valid}, 32'd1);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        Req = 16'h0000;
        tick();
        tick();
        check("err_timeout", err_seen, 32'd1);

        // requester 7 drops its request: release without Err
        do_reset();
        w   = 16'h0080;
        Req = 16'h0080;
        push_exp(4'd7);
        tick();
        check("drop_valid", {31'd0, Valid}, 32'd1);
        Req = 16'h0000;
        tick();
        check("drop_release", {31'd0, Valid}, 32'd0);
        check("drop_err", {31'd0, Err}, 32'd0);
        check("drop_ptr", {28'd0, dbg_ptr}, 32'd8);
        tick();
        tick();

        // Ack coincident with the timeout edge: Ack wins
        Req = 16'h0080;
        push_exp(4'd7);
        tick();
        for (int k = 0; k < 14; k++) tick();
        check("coinc_still_valid", {31'd0, Valid}, 32'd1);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        Req = 16'h0000;
        check("coinc_release", {31'd0, Valid}, 32'd0);
        check("coinc_err", {31'd0, Err}, 32'd0);
        check("coinc_ptr", {28'd0, dbg_ptr}, 32'd8);
        tick();
        tick();
        check("err_coinc", err_seen, 32'd1);

        // asynchronous reset in the middle of a grant
        do_reset();
        w = 16'h0022;
        do_grant(16'h0008, 16'h0000, 4'd3);
        Req = 16'h0002;
        push_exp(4'd1);
        tick();
        check("abort_pre_valid", {31'd0, Valid}, 32'd1);
        tick();
        tick();
        #2;
        Resetn = 1'b0;
        #1;
        check("abort_valid", {31'd0, Valid}, 32'd0);
        check("abort_grant", {16'd0, Grant}, 32'd0);
        check("abort_sel", {28'd0, Sel}, 32'd0);
        check("abort_f", {31'd0, F}, 32'd0);
        check("abort_err", {31'd0, Err}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        Req = 16'h0000;
        tick();
        Resetn = 1'b1;
        check("abort_ptr", {28'd0, dbg_ptr}, 32'd0);
        do_grant(16'h0022, 16'h0000, 4'd1);
        tick();
        check("err_abort", err_seen, 32'd1);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
